cpu7_ifu_imem_resp: RTL

- Responder (memory side) of the IFU instruction-fetch request interface; the IFU fetch datapath is the initiator.
- Accepts one fetch request at a time and reads one 32-bit word from a synchronous single-port instruction SRAM.
- Returns the word with a fixed, parameterised latency, reports misaligned fetches as exceptions, and honours inst_cancel.
- Sits between the IFU and the instruction SRAM/bridge in the core top level.

---
 rtl/cpu7_ifu_imem_resp_if.sv | 26 ++
 rtl/cpu7_ifu_imem_resp.sv | 108 ++++++++++
 2 files changed

// File: rtl/cpu7_ifu_imem_resp_if.sv
// IFU instruction-fetch request/response bundle between the fetch datapath
// (master, initiator) and the instruction-memory responder (slave).
interface cpu7_ifu_imem_resp_if;
   logic         inst_req;
   logic [31:0]  inst_addr;
   logic         inst_addr_ok;
   logic         inst_cancel;
   logic         inst_valid;
   logic [127:0] inst_rdata;
   logic [1:0]   inst_count;
   logic         inst_ex;
   logic [5:0]   inst_exccode;
   logic         inst_uncache;

   modport master (
      output inst_req, inst_addr, inst_cancel,
      input  inst_addr_ok, inst_valid, inst_rdata, inst_count,
             inst_ex, inst_exccode, inst_uncache
   );

   modport slave (
      input  inst_req, inst_addr, inst_cancel,
      output inst_addr_ok, inst_valid, inst_rdata, inst_count,
             inst_ex, inst_exccode, inst_uncache
   );
endinterface

// File: rtl/cpu7_ifu_imem_resp.sv
// IFU fetch responder: one outstanding request, fixed latency 1+WAIT_STATES.
// Optional macro CPU7_IMEM_RANGE_CHK_EN faults aligned fetches outside the SRAM window.
module cpu7_ifu_imem_resp #(
   parameter int          MEM_AW      = 14,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] MEM_BASE    = 32'h1c000000
) (
   input  logic                  clock,
   input  logic                  resetn,
   cpu7_ifu_imem_resp_if.slave   ifu,
   output logic                  mem_en,
   output logic [MEM_AW-1:0]     mem_addr,
   input  logic [31:0]           mem_rdata
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [2:0] WS_CNT  = 3'(WAIT_STATES);
   localparam logic [5:0] EXC_ADEF = 6'h08;

   state_t      state, state_next;
   logic [2:0]  cnt, cnt_next;
   logic        err_q, unc_q, first_q;
   logic [31:0] data_q;

   logic        rsp_cycle;
   logic        accept;
   logic        addr_err;
   logic        addr_unc;

   assign rsp_cycle = (state == BUSY) && (cnt == 3'd0);
   // Accept depends only on state and control inputs, never on inst_addr.
   assign accept    = resetn & ifu.inst_req & ~ifu.inst_cancel & ((state == IDLE) | rsp_cycle);
   assign addr_unc  = (ifu.inst_addr[31:29] == 3'b101);

`ifdef CPU7_IMEM_RANGE_CHK_EN
   localparam logic [31:0] WIN_BYTES = 32'(1) << (MEM_AW + 2);
   logic [31:0] win_off;
   assign win_off  = ifu.inst_addr - MEM_BASE;
   // Addresses below the base wrap to large offsets and so fail the bound too.
   assign addr_err = (|ifu.inst_addr[1:0]) | (win_off >= WIN_BYTES);
   assign mem_addr = win_off[MEM_AW+1:2];
`else
   assign addr_err = |ifu.inst_addr[1:0];
   assign mem_addr = ifu.inst_addr[MEM_AW+1:2];
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      if (ifu.inst_cancel) begin
         state_next = IDLE;
         cnt_next   = 3'd0;
      end else if (accept) begin
         state_next = BUSY;
         cnt_next   = WS_CNT;
      end else if (rsp_cycle) begin
         state_next = IDLE;
         cnt_next   = 3'd0;
      end else if (state == BUSY) begin
         cnt_next   = cnt - 3'd1;
      end
   end

   // first_q marks the BUSY cycle in which the SRAM read data is on mem_rdata.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         err_q   <= 1'b0;
         unc_q   <= 1'b0;
         first_q <= 1'b0;
         data_q  <= 32'd0;
      end else begin
         first_q <= accept;
         if (accept) begin
            err_q <= addr_err;
            unc_q <= addr_unc;
         end
         if (first_q && (state == BUSY)) begin
            data_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      ifu.inst_addr_ok = accept;
      mem_en           = accept & ~addr_err;
      ifu.inst_valid   = resetn & rsp_cycle & ~ifu.inst_cancel;
      ifu.inst_count   = {1'b0, ifu.inst_valid};
      ifu.inst_ex      = ifu.inst_valid & err_q;
      ifu.inst_exccode = ifu.inst_ex ? EXC_ADEF : 6'd0;
      ifu.inst_uncache = ifu.inst_valid & unc_q;
      ifu.inst_rdata   = 128'd0;
      if (ifu.inst_valid && !err_q) begin
         ifu.inst_rdata[31:0] = first_q ? mem_rdata : data_q;
      end
   end

endmodule
